user_id_enroll: RTL and testbench
=================================

# user_id_enroll

Enrollment writer for the user-ID table: an authenticated administrator keys a new 16-bit user ID as four 4-bit toggle entries, commits it, and the block scans the table for duplicates and a free slot, then writes the ID into the first free slot. It is the writing end of the ID table that the login/authentication path reads, and it shares the same toggle/button front panel and LED conventions.

## Interface
Parameters:
- ID_W, 16, user-ID width (four nibbles)
- DEPTH, 8, table entries; address width 3

Ports:
- clock  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- toggle_entry  in  4  nibble presented on the toggles
- enter_button  in  1  level; rising edge shifts toggle_entry in
- commit_button  in  1  level; rising edge starts enrollment
- cancel  in  1  level; synchronous abort to IDLE while high
- admin_access  in  1  high while an admin session is active; enables the block
- tbl_addr  out  3  table address (registered)
- tbl_wdata  out  17  {valid, id}; write data (registered)
- tbl_we  out  1  one-cycle write strobe (registered)
- tbl_rdata  in  17  {valid, id}; read data, 1-cycle synchronous latency
- busy  out  1  high in SCAN and WRITE
- green_led_enroll  out  1  success indicator
- red_led_enroll  out  1  error indicator
- err_code  out  2  0 none, 1 duplicate, 2 table full, 3 incomplete entry
- assigned_slot  out  3  slot written on success

## Operation
- Reset value of every output: 0.
- Rising edges are detected internally from a one-cycle-delayed copy of each button; a held button produces exactly one event.
- States: IDLE, COLLECT, SCAN, WRITE, DONE, ERROR.
- IDLE: nibble count cleared. An enter edge with admin_access=1 loads the nibble and moves to COLLECT with count=1.
- COLLECT: each enter edge shifts MSB-first, entered = {entered[11:0], toggle_entry}. Count saturates at 4; further entries keep shifting, so the oldest nibble is dropped.
- Commit edge in COLLECT:
  - count<4: go to ERROR with err_code=3.
  - entered==16'h0000 (reserved): go to ERROR with err_code=3.
  - otherwise: go to SCAN.
- SCAN reads addresses 0..DEPTH-1 back to back. Each returned entry is compared one cycle after its address is issued.
  - dup_flag is set when valid=1 and the entry's id matches entered.
  - free_slot latches the lowest address with valid=0.
  - The full scan always completes; there is no early exit.
- After the last compare:
  - dup_flag set: ERROR, err_code=1. Duplicate has priority over full.
  - no free slot: ERROR, err_code=2.
  - otherwise: WRITE.
- WRITE: for exactly one cycle, tbl_we=1, tbl_addr=free_slot, tbl_wdata={1'b1, entered}. Then DONE.
- DONE: green_led_enroll=1, assigned_slot=free_slot.
- ERROR: red_led_enroll=1 and err_code are held.
- DONE and ERROR both hold until the next enter edge, which starts a new COLLECT with count=1, or until cancel.
- cancel=1 or admin_access=0 in IDLE, COLLECT, SCAN, DONE or ERROR returns the FSM to IDLE next cycle. LEDs and err_code clear, and no write occurs.
- A WRITE cycle already entered always completes; the abort takes effect in the following cycle.
- Simultaneous enter and commit edges: commit wins and the nibble is ignored.
- Button edges are ignored while in SCAN and WRITE.
- Asynchronous rst at any point, including mid-scan: FSM to IDLE, tbl_we=0 immediately, and the partial entry is discarded.

## Timing
- Commit edge detected in cycle t.
- SCAN issues address k in cycle t+1+k; its data is compared in cycle t+2+k. The last compare is in t+9.
- Success path: tbl_we high in t+10 only; green_led_enroll and assigned_slot valid from t+11.
- Error path: red_led_enroll and err_code valid from t+10.
- Incomplete-entry error: red_led_enroll and err_code valid at t+1.
- busy high t+1..t+10 on the scan path.
- Fixed latency, independent of table contents.

## Structure
- Shared package user_pkg holds:
  - ID_W and DEPTH
  - the err_code constants ERR_NONE, ERR_DUP, ERR_FULL, ERR_INCOMPLETE
  - the state encoding typedef
  - the reserved-ID constant 16'h0000
- One natural sub-module, button_edge: a registered rising-edge detector with asynchronous reset, instantiated once per button.
- The FSM, nibble shift register and scan datapath live in user_id_enroll.

## Test plan
- Empty table; admin enters 1,2,3,4 then commits -> tbl_we in t+10 at addr 0 with wdata 17'h1_1234; green_led_enroll and assigned_slot=0 from t+11.
- Slot 0 holds 0x1234 and slot 3 is free; enroll 0x1234 -> no write; red_led_enroll, err_code=1 at t+10.
- All 8 slots valid with distinct IDs; enroll 0xBEEF -> err_code=2 and no tbl_we. With 0xBEEF also present in a slot -> err_code=1 (priority).
- Three nibbles then commit -> err_code=3 at t+1. Five nibbles 1,2,3,4,5 then commit -> entry 0x2345 written.
- admin_access dropped mid-SCAN -> IDLE next cycle, tbl_we stays 0.
- rst pulsed at t+5 -> all outputs 0 asynchronously; no write afterwards.

Source files
------------

// File: rtl/user_pkg.sv
// Shared constants and types for the user-ID table: geometry, error codes,
// the enrollment state encoding and the reserved ID value.
package user_pkg;
    localparam int ID_W   = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_DUP        = 2'd1;
    localparam logic [1:0] ERR_FULL       = 2'd2;
    localparam logic [1:0] ERR_INCOMPLETE = 2'd3;

    localparam logic [ID_W-1:0] RESERVED_ID = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SCAN,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_t;
endpackage

// File: rtl/button_edge.sv
// Rising-edge detector for a level button: compares the live level with a
// one-cycle-delayed copy, so a held button yields a single one-cycle event.
module button_edge (
    input  logic i_clock,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_rise
);
    logic r_prev;

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_prev;
endmodule

// File: rtl/user_id_enroll.sv
// Enrollment writer: collects a 16-bit ID from toggle nibbles, scans the whole
// table for duplicates and the lowest free slot, then writes the ID there.
module user_id_enroll
    import user_pkg::*;
(
    input  logic              clock,
    input  logic              rst,
    input  logic [3:0]        toggle_entry,
    input  logic              enter_button,
    input  logic              commit_button,
    input  logic              cancel,
    input  logic              admin_access,
    output logic [ADDR_W-1:0] tbl_addr,
    output logic [ID_W:0]     tbl_wdata,
    output logic              tbl_we,
    input  logic [ID_W:0]     tbl_rdata,
    output logic              busy,
    output logic              green_led_enroll,
    output logic              red_led_enroll,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] assigned_slot
);
    localparam int CW = ADDR_W + 1;

    state_t            r_state;
    logic [ID_W-1:0]   r_entered;
    logic [2:0]        r_count;
    logic [CW-1:0]     r_cnt;
    logic              r_dup;
    logic              r_free_found;
    logic [ADDR_W-1:0] r_free_slot;

    logic w_enter_rise;
    logic w_commit_rise;
    logic w_enter_ev;
    logic w_abort;
    logic w_cmp_en;
    logic w_last;
    logic w_hit;
    logic w_free;
    logic w_dup_all;
    logic w_free_all;
    logic [ADDR_W-1:0] w_cmp_idx;
    logic [ADDR_W-1:0] w_slot_all;

    button_edge u_enter_edge (
        .i_clock (clock),
        .i_rst   (rst),
        .i_btn   (enter_button),
        .o_rise  (w_enter_rise)
    );

    button_edge u_commit_edge (
        .i_clock (clock),
        .i_rst   (rst),
        .i_btn   (commit_button),
        .o_rise  (w_commit_rise)
    );

    // A commit edge swallows a coincident enter edge.
    assign w_enter_ev = w_enter_rise & ~w_commit_rise;
    assign w_abort    = cancel | ~admin_access;

    // r_cnt counts SCAN cycles; read data for address r_cnt-1 is present now.
    assign w_cmp_en   = (r_state == ST_SCAN) && (r_cnt != '0);
    assign w_last     = (r_state == ST_SCAN) && (r_cnt == CW'(DEPTH));
    assign w_cmp_idx  = r_cnt[ADDR_W-1:0] - ADDR_W'(1);
    assign w_hit      = w_cmp_en && tbl_rdata[ID_W] && (tbl_rdata[ID_W-1:0] == r_entered);
    assign w_free     = w_cmp_en && !tbl_rdata[ID_W];
    assign w_dup_all  = r_dup | w_hit;
    assign w_free_all = r_free_found | w_free;
    assign w_slot_all = r_free_found ? r_free_slot : w_cmp_idx;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_entered        <= '0;
            r_count          <= '0;
            r_cnt            <= '0;
            r_dup            <= 1'b0;
            r_free_found     <= 1'b0;
            r_free_slot      <= '0;
            tbl_addr         <= '0;
            tbl_wdata        <= '0;
            tbl_we           <= 1'b0;
            busy             <= 1'b0;
            green_led_enroll <= 1'b0;
            red_led_enroll   <= 1'b0;
            err_code         <= ERR_NONE;
            assigned_slot    <= '0;
        end else begin
            tbl_we <= 1'b0;
            // A write already under way is never interrupted.
            if (r_state != ST_WRITE && w_abort) begin
                r_state          <= ST_IDLE;
                r_count          <= '0;
                busy             <= 1'b0;
                green_led_enroll <= 1'b0;
                red_led_enroll   <= 1'b0;
                err_code         <= ERR_NONE;
                assigned_slot    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_count <= '0;
                        if (w_enter_ev) begin
                            r_entered <= {{(ID_W-4){1'b0}}, toggle_entry};
                            r_count   <= 3'd1;
                            r_state   <= ST_COLLECT;
                        end
                    end
                    ST_COLLECT: begin
                        if (w_commit_rise) begin
                            if (r_count < 3'd4 || r_entered == RESERVED_ID) begin
                                r_state        <= ST_ERROR;
                                red_led_enroll <= 1'b1;
                                err_code       <= ERR_INCOMPLETE;
                            end else begin
                                r_state      <= ST_SCAN;
                                busy         <= 1'b1;
                                r_cnt        <= '0;
                                tbl_addr     <= '0;
                                r_dup        <= 1'b0;
                                r_free_found <= 1'b0;
                                r_free_slot  <= '0;
                            end
                        end else if (w_enter_ev) begin
                            r_entered <= {r_entered[ID_W-5:0], toggle_entry};
                            if (r_count < 3'd4) begin
                                r_count <= r_count + 3'd1;
                            end
                        end
                    end
                    ST_SCAN: begin
                        r_cnt        <= r_cnt + CW'(1);
                        r_dup        <= w_dup_all;
                        r_free_found <= w_free_all;
                        r_free_slot  <= w_slot_all;
                        if (r_cnt < CW'(DEPTH - 1)) begin
                            tbl_addr <= r_cnt[ADDR_W-1:0] + ADDR_W'(1);
                        end
                        if (w_last) begin
                            if (w_dup_all) begin
                                r_state        <= ST_ERROR;
                                busy           <= 1'b0;
                                red_led_enroll <= 1'b1;
                                err_code       <= ERR_DUP;
                            end else if (!w_free_all) begin
                                r_state        <= ST_ERROR;
                                busy           <= 1'b0;
                                red_led_enroll <= 1'b1;
                                err_code       <= ERR_FULL;
                            end else begin
                                r_state   <= ST_WRITE;
                                tbl_we    <= 1'b1;
                                tbl_addr  <= w_slot_all;
                                tbl_wdata <= {1'b1, r_entered};
                            end
                        end
                    end
                    ST_WRITE: begin
                        r_state          <= ST_DONE;
                        busy             <= 1'b0;
                        green_led_enroll <= 1'b1;
                        assigned_slot    <= r_free_slot;
                    end
                    ST_DONE, ST_ERROR: begin
                        if (w_enter_ev) begin
                            r_state          <= ST_COLLECT;
                            r_entered        <= {{(ID_W-4){1'b0}}, toggle_entry};
                            r_count          <= 3'd1;
                            green_led_enroll <= 1'b0;
                            red_led_enroll   <= 1'b0;
                            err_code         <= ERR_NONE;
                            assigned_slot    <= '0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_user_id_enroll.sv
// Randomised enrollment bench: a table RAM, an outcome model computed from the
// keyed nibbles and table contents, and a per-cycle output checker.
module tb_user_id_enroll;
    import user_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              rst;
    logic [3:0]        toggle_entry;
    logic              enter_button;
    logic              commit_button;
    logic              cancel;
    logic              admin_access;
    logic [ADDR_W-1:0] tbl_addr;
    logic [ID_W:0]     tbl_wdata;
    logic              tbl_we;
    logic [ID_W:0]     tbl_rdata;
    logic              busy;
    logic              green_led_enroll;
    logic              red_led_enroll;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] assigned_slot;

    user_id_enroll dut (
        .clock            (clock),
        .rst              (rst),
        .toggle_entry     (toggle_entry),
        .enter_button     (enter_button),
        .commit_button    (commit_button),
        .cancel           (cancel),
        .admin_access     (admin_access),
        .tbl_addr         (tbl_addr),
        .tbl_wdata        (tbl_wdata),
        .tbl_we           (tbl_we),
        .tbl_rdata        (tbl_rdata),
        .busy             (busy),
        .green_led_enroll (green_led_enroll),
        .red_led_enroll   (red_led_enroll),
        .err_code         (err_code),
        .assigned_slot    (assigned_slot)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Table RAM with one-cycle registered read.
    logic [ID_W:0] mem      [DEPTH];
    logic [ID_W:0] init_tbl [DEPTH];
    logic [ID_W:0] ref_tbl  [DEPTH];
    logic          load_tbl = 1'b0;
    always @(posedge clock) begin
        if (load_tbl) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_tbl[i];
        end else if (tbl_we) begin
            mem[tbl_addr] <= tbl_wdata;
        end
        tbl_rdata <= mem[tbl_addr];
    end

    logic [3:0]        cur_nibs [$];
    bit                txn_active = 1'b0;
    int                cmt_cyc    = 0;
    bit                exp_ok     = 1'b0;
    bit                exp_scan   = 1'b0;
    logic [1:0]        exp_err    = ERR_NONE;
    logic [ADDR_W-1:0] exp_slot   = '0;
    logic [ID_W:0]     exp_wdata  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Outcome from the rules: the ID is the last four nibbles keyed; too few or
    // the reserved ID is rejected; otherwise duplicate beats full, else lowest free slot.
    task automatic predict();
        logic [ID_W-1:0] id = '0;
        int  free = -1;
        bit  dup  = 1'b0;
        foreach (cur_nibs[i]) id = {id[ID_W-5:0], cur_nibs[i]};
        exp_ok = 1'b0; exp_scan = 1'b0; exp_err = ERR_NONE; exp_slot = '0; exp_wdata = '0;
        if (cur_nibs.size() < 4 || id == 16'h0000) begin
            exp_err = ERR_INCOMPLETE;
        end else begin
            exp_scan = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (ref_tbl[i][ID_W] && ref_tbl[i][ID_W-1:0] == id) dup = 1'b1;
                if (!ref_tbl[i][ID_W] && free < 0) free = i;
            end
            if (dup) exp_err = ERR_DUP;
            else if (free < 0) exp_err = ERR_FULL;
            else begin
                exp_ok    = 1'b1;
                exp_slot  = ADDR_W'(free);
                exp_wdata = {1'b1, id};
            end
        end
    endtask

    int chk_rel;
    always @(negedge clock) begin
        chk_rel = cyc - cmt_cyc;
        check("tbl_we", 32'(tbl_we), 32'(txn_active && exp_ok && chk_rel == 10));
        if (txn_active) begin
            if (chk_rel == 0) begin
                check("busy_t0", 32'(busy), 32'd0);
            end else if (!exp_scan) begin
                check("busy_inc", 32'(busy), 32'd0);
                check("red_inc", 32'(red_led_enroll), 32'd1);
                check("err_inc", 32'(err_code), 32'(ERR_INCOMPLETE));
                check("green_inc", 32'(green_led_enroll), 32'd0);
            end else if (chk_rel <= 9 || (exp_ok && chk_rel == 10)) begin
                check("busy_scan", 32'(busy), 32'd1);
                check("red_scan", 32'(red_led_enroll), 32'd0);
                check("green_scan", 32'(green_led_enroll), 32'd0);
                if (chk_rel == 10) begin
                    check("wr_addr", 32'(tbl_addr), 32'(exp_slot));
                    check("wr_data", 32'(tbl_wdata), 32'(exp_wdata));
                end
            end else if (exp_ok) begin
                check("busy_done", 32'(busy), 32'd0);
                check("green_done", 32'(green_led_enroll), 32'd1);
                check("slot_done", 32'(assigned_slot), 32'(exp_slot));
                check("red_done", 32'(red_led_enroll), 32'd0);
                check("err_done", 32'(err_code), 32'(ERR_NONE));
            end else begin
                check("busy_err", 32'(busy), 32'd0);
                check("red_err", 32'(red_led_enroll), 32'd1);
                check("err_err", 32'(err_code), 32'(exp_err));
                check("green_err", 32'(green_led_enroll), 32'd0);
            end
        end
    end

    task automatic load_table();
        load_tbl = 1'b1;
        @(posedge clock); #1 load_tbl = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_tbl[i] = init_tbl[i];
    endtask

    task automatic press_enter(input logic [3:0] nib);
        toggle_entry = nib; enter_button = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1 enter_button = 1'b0; toggle_entry = 4'($urandom);
        @(posedge clock); #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin @(posedge clock); #1; end
    endtask

    task automatic run_txn(input bit simul);
        predict();
        foreach (cur_nibs[i]) press_enter(cur_nibs[i]);
        commit_button = 1'b1;
        if (simul) begin enter_button = 1'b1; toggle_entry = 4'($urandom_range(1, 15)); end
        cmt_cyc = cyc; txn_active = 1'b1;
        repeat ($urandom_range(1, 2)) @(posedge clock);
        #1 commit_button = 1'b0; enter_button = 1'b0;
        wait_cyc(cmt_cyc + 15);
        txn_active = 1'b0;
        if (exp_ok) ref_tbl[exp_slot] = exp_wdata;
        $display("txn %0d nibbles simul=%0d -> ok=%0d err=%0d slot=%0d", cur_nibs.size(), simul, exp_ok, exp_err, exp_slot);
    endtask

    task automatic fill_table(input int mode);
        for (int i = 0; i < DEPTH; i++) begin
            case (mode)
                0: init_tbl[i] = '0;
                1: init_tbl[i] = {1'b1, 16'h1000 + 16'(i)};
                default: init_tbl[i] = {1'($urandom_range(0, 1)), 16'($urandom)};
            endcase
        end
    endtask

    int               c0;
    int               n;
    int               pick;
    logic [ID_W-1:0]  target;

    initial begin
        rst = 1'b1; toggle_entry = '0; enter_button = 1'b0; commit_button = 1'b0;
        cancel = 1'b0; admin_access = 1'b1;
        repeat (3) @(posedge clock); #1;
        check("rst_we", 32'(tbl_we), 32'd0);
        check("rst_addr", 32'(tbl_addr), 32'd0);
        check("rst_wdata", 32'(tbl_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_green", 32'(green_led_enroll), 32'd0);
        check("rst_red", 32'(red_led_enroll), 32'd0);
        check("rst_err", 32'(err_code), 32'd0);
        check("rst_slot", 32'(assigned_slot), 32'd0);
        rst = 1'b0;

        // Empty table, 1-2-3-4.
        fill_table(0); load_table();
        cur_nibs = '{4'h1, 4'h2, 4'h3, 4'h4}; run_txn(1'b0);
        check("model_wdata_1234", 32'(exp_wdata), 32'h0001_1234);
        check("mem0_1234", 32'(mem[0]), 32'h0001_1234);

        // Duplicate with a free slot available.
        fill_table(1); init_tbl[0] = {1'b1, 16'h1234}; init_tbl[3] = '0; load_table();
        run_txn(1'b0);
        check("model_err_dup", 32'(exp_err), 32'd1);
        check("mem3_untouched", 32'(mem[3][ID_W]), 32'd0);

        // Full table, then full plus duplicate.
        fill_table(1); load_table();
        cur_nibs = '{4'hB, 4'hE, 4'hE, 4'hF}; run_txn(1'b0);
        check("model_err_full", 32'(exp_err), 32'd2);
        init_tbl[5] = {1'b1, 16'hBEEF}; load_table();
        run_txn(1'b0);
        check("model_err_dupfull", 32'(exp_err), 32'd1);

        // Short entry, overlong entry, reserved ID, simultaneous edges.
        fill_table(0); load_table();
        cur_nibs = '{4'h1, 4'h2, 4'h3}; run_txn(1'b0);
        check("model_err_short", 32'(exp_err), 32'd3);
        cur_nibs = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5}; run_txn(1'b0);
        check("model_wdata_2345", 32'(exp_wdata), 32'h0001_2345);
        check("mem0_2345", 32'(mem[0]), 32'h0001_2345);
        cur_nibs = '{4'h0, 4'h0, 4'h0, 4'h0}; run_txn(1'b0);
        cur_nibs = '{4'h1, 4'h2, 4'h3}; run_txn(1'b1);

        // admin_access dropped mid-scan.
        cur_nibs = '{4'hA, 4'h5, 4'hA, 4'h5};
        foreach (cur_nibs[i]) press_enter(cur_nibs[i]);
        commit_button = 1'b1; c0 = cyc;
        wait_cyc(c0 + 4); admin_access = 1'b0;
        @(negedge clock); check("busy_pre_abort", 32'(busy), 32'd1);
        @(negedge clock); check("busy_abort", 32'(busy), 32'd0);
        check("red_abort", 32'(red_led_enroll), 32'd0);
        check("green_abort", 32'(green_led_enroll), 32'd0);
        @(posedge clock); #1 commit_button = 1'b0;
        repeat (12) @(posedge clock); #1 admin_access = 1'b1;

        // Asynchronous reset mid-scan.
        cur_nibs = '{4'h7, 4'h7, 4'h7, 4'h7};
        foreach (cur_nibs[i]) press_enter(cur_nibs[i]);
        commit_button = 1'b1; c0 = cyc;
        wait_cyc(c0 + 5);
        #2 rst = 1'b1;
        #1 check("arst_busy", 32'(busy), 32'd0);
        check("arst_we", 32'(tbl_we), 32'd0);
        check("arst_addr", 32'(tbl_addr), 32'd0);
        check("arst_err", 32'(err_code), 32'd0);
        @(posedge clock); #1 rst = 1'b0; commit_button = 1'b0;
        repeat (12) @(posedge clock); #1;

        // Cancel while DONE.
        cur_nibs = '{4'h0, 4'hF, 4'h0, 4'hF}; run_txn(1'b0);
        check("model_slot_0f0f", 32'(exp_slot), 32'd1);
        cancel = 1'b1;
        @(negedge clock); check("green_hold", 32'(green_led_enroll), 32'd1);
        @(posedge clock); #1 cancel = 1'b0;
        @(negedge clock); check("green_cancel", 32'(green_led_enroll), 32'd0);
        @(posedge clock); #1;

        // Randomised transactions.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                fill_table(int'($urandom_range(0, 2))); load_table();
            end
            n    = ($urandom_range(0, 9) < 7) ? 4 : int'($urandom_range(1, 6));
            pick = int'($urandom_range(0, 15));
            if (pick < 4) target = ref_tbl[$urandom_range(0, DEPTH-1)][ID_W-1:0];
            else if (pick == 4) target = '0;
            else target = 16'($urandom);
            cur_nibs.delete();
            if (n >= 4) begin
                for (int k = 0; k < n - 4; k++) cur_nibs.push_back(4'($urandom));
                for (int k = 3; k >= 0; k--) cur_nibs.push_back(target[k*4 +: 4]);
            end else begin
                for (int k = 0; k < n; k++) cur_nibs.push_back(4'($urandom));
            end
            run_txn($urandom_range(0, 9) == 0);
        end

        for (int i = 0; i < DEPTH; i++) check("table_final", 32'(mem[i]), 32'(ref_tbl[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
